wb_stage: RTL and testbench

Registered, parametrised writeback stage for the in-order core. It sits between the MEM stage and the register file and accepts one instruction per cycle through a valid/ready handshake. It selects the result from EXE, MEM or CSR and aligns and sign- or zero-extends load data. It then writes the register file, emits a retire pulse with the PC, and counts retired instructions.

---
 rtl/wb_stage.sv | 184 ++++++++++++++++++
 tb/tb_wb_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// ----------------------------------------------------------------------------
// wb_stage
//
// Registered writeback stage that sits between MEM and the register file. It
// holds one instruction in a single-entry register and takes a new one each
// cycle through a valid/ready handshake. It picks the result from EXE, MEM or
// CSR and writes the register file. On commit it raises a retire pulse with
// the PC and advances the retired-instruction counter.
//
// Build option:
//   WB_LOAD_EXT_EN  defined   : MEM data is shifted by in_addr_lo bytes and
//                               sign/zero-extended from in_ld_size.
//                   undefined : MEM data passes through unchanged. MEM is
//                               then expected to format loads itself.
//
// Parameters:
//   XLEN     datapath and PC width (XLEN >= 32)
//   RADDR_W  register-file address width
//   CNT_W    retired-instruction counter width
//
// Ports:
//   clk, rst          core clock, synchronous active-high reset
//   flush             kills the held entry and any accept in the same cycle
//   commit_ready      downstream can take a commit this cycle
//   in_valid/in_ready handshake with MEM
//   in_pc, in_rd_addr, in_rd_wen, in_sel, in_*_data
//                     instruction payload and candidate results
//   in_ld_size, in_ld_unsigned, in_addr_lo
//                     load formatting controls
//   rf_wen/rf_waddr/rf_wdata
//                     register-file write port
//   retire_valid/retire_pc
//                     retire pulse and PC of the retiring instruction
//   instret           retired-instruction count (wraps)
// ----------------------------------------------------------------------------
module wb_stage #(
    parameter int XLEN    = 64,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               commit_ready,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [RADDR_W-1:0] in_rd_addr,
    input  logic               in_rd_wen,
    input  logic [1:0]         in_sel,
    input  logic [XLEN-1:0]    in_exe_data,
    input  logic [XLEN-1:0]    in_mem_data,
    input  logic [XLEN-1:0]    in_csr_data,
    input  logic [1:0]         in_ld_size,
    input  logic               in_ld_unsigned,
    input  logic [2:0]         in_addr_lo,
    output logic               rf_wen,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]    rf_wdata,
    output logic               retire_valid,
    output logic [XLEN-1:0]    retire_pc,
    output logic [CNT_W-1:0]   instret
);

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_EXE  = 2'b01;
    localparam logic [1:0] SEL_MEM  = 2'b10;
    localparam logic [1:0] SEL_CSR  = 2'b11;

    logic               valid_q;
    logic [XLEN-1:0]    pc_q;
    logic [RADDR_W-1:0] rd_q;
    logic               wen_q;
    logic [XLEN-1:0]    data_q;
    logic [CNT_W-1:0]   instret_q;

    logic               accept;
    logic               commit;
    logic [XLEN-1:0]    ld_data;
    logic [XLEN-1:0]    sel_data;
    logic               sel_wen;

    assign in_ready = !rst && (!valid_q || commit_ready);
    assign accept   = in_valid && in_ready;
    // Reset gates the commit so an entry held across reset never retires.
    assign commit   = valid_q && commit_ready && !flush && !rst;

`ifdef WB_LOAD_EXT_EN
    logic [XLEN-1:0] shifted;
    logic            sign_bit;
    int unsigned     field_w;

    assign shifted = in_mem_data >> {in_addr_lo, 3'b000};

    always_comb begin
        field_w  = XLEN;
        sign_bit = 1'b0;
        case (in_ld_size)
            2'b00: begin
                field_w  = 8;
                sign_bit = shifted[7];
            end
            2'b01: begin
                field_w  = 16;
                sign_bit = shifted[15];
            end
            2'b10: begin
                field_w  = 32;
                sign_bit = shifted[31];
            end
            default: begin
                field_w  = XLEN;
                sign_bit = 1'b0;
            end
        endcase
        // Dword keeps every bit, so its extension bit is never used.
        if (in_ld_unsigned) begin
            sign_bit = 1'b0;
        end
        ld_data = '0;
        for (int i = 0; i < XLEN; i++) begin
            ld_data[i] = (i < int'(field_w)) ? shifted[i] : sign_bit;
        end
    end
`else
    logic ld_ctrl_unused;

    assign ld_ctrl_unused = ^{in_ld_size, in_ld_unsigned, in_addr_lo};
    assign ld_data        = in_mem_data;
`endif

    always_comb begin
        sel_data = '0;
        case (in_sel)
            SEL_EXE:  sel_data = in_exe_data;
            SEL_MEM:  sel_data = ld_data;
            SEL_CSR:  sel_data = in_csr_data;
            SEL_NONE: sel_data = '0;
            default:  sel_data = '0;
        endcase
    end

    // x0 and no-result instructions retire without touching the register file.
    assign sel_wen = in_rd_wen && (in_sel != SEL_NONE) && (in_rd_addr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            rd_q      <= '0;
            wen_q     <= 1'b0;
            data_q    <= '0;
            instret_q <= '0;
        end else begin
            if (flush) begin
                valid_q <= 1'b0;
            end else if (accept) begin
                valid_q <= 1'b1;
            end else if (commit) begin
                valid_q <= 1'b0;
            end

            // A flushed accept leaves the payload untouched so outputs stay put.
            if (accept && !flush) begin
                pc_q   <= in_pc;
                rd_q   <= in_rd_addr;
                wen_q  <= sel_wen;
                data_q <= sel_data;
            end

            if (commit) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    assign rf_wen       = commit && wen_q;
    assign rf_waddr     = rd_q;
    assign rf_wdata     = data_q;
    assign retire_valid = commit;
    assign retire_pc    = pc_q;
    assign instret      = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

    localparam int XLEN    = 64;
    localparam int RADDR_W = 5;
    localparam int CNT_W   = 64;

    logic               clk;
    logic               rst;
    logic               flush;
    logic               commit_ready;
    logic               in_valid;
    logic               in_ready;
    logic [XLEN-1:0]    in_pc;
    logic [RADDR_W-1:0] in_rd_addr;
    logic               in_rd_wen;
    logic [1:0]         in_sel;
    logic [XLEN-1:0]    in_exe_data;
    logic [XLEN-1:0]    in_mem_data;
    logic [XLEN-1:0]    in_csr_data;
    logic [1:0]         in_ld_size;
    logic               in_ld_unsigned;
    logic [2:0]         in_addr_lo;
    logic               rf_wen;
    logic [RADDR_W-1:0] rf_waddr;
    logic [XLEN-1:0]    rf_wdata;
    logic               retire_valid;
    logic [XLEN-1:0]    retire_pc;
    logic [CNT_W-1:0]   instret;

    int passed = 0;
    int total  = 0;
    logic [CNT_W-1:0] exp_instret = '0;

    wb_stage #(.XLEN(XLEN), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .commit_ready(commit_ready),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rd_addr(in_rd_addr), .in_rd_wen(in_rd_wen), .in_sel(in_sel),
        .in_exe_data(in_exe_data), .in_mem_data(in_mem_data), .in_csr_data(in_csr_data),
        .in_ld_size(in_ld_size), .in_ld_unsigned(in_ld_unsigned), .in_addr_lo(in_addr_lo),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .retire_valid(retire_valid), .retire_pc(retire_pc), .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic v, input logic [RADDR_W-1:0] rd, input logic [1:0] sel,
                         input logic [XLEN-1:0] exe, input logic [XLEN-1:0] pc);
        in_valid    = v;
        in_rd_addr  = rd;
        in_rd_wen   = 1'b1;
        in_sel      = sel;
        in_exe_data = exe;
        in_pc       = pc;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; commit_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", in_ready); else passed++;
            total++; if (rf_wen !== 1'b0) $display("FAIL reset_rf_wen got=%b exp=0", rf_wen); else passed++;
            total++; if (instret !== '0) $display("FAIL reset_instret got=%0d exp=0", instret); else passed++;
        end
        total++; if (retire_valid !== 1'b0) $display("FAIL reset_retire_valid got=%b exp=0", retire_valid); else passed++;
        total++; if (rf_wdata !== '0 || retire_pc !== '0 || rf_waddr !== '0)
            $display("FAIL reset_data got=%h/%h/%h exp=0", rf_wdata, retire_pc, rf_waddr); else passed++;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL release_in_ready got=%b exp=1", in_ready); else passed++;
        total++; if (rf_wen !== 1'b0) $display("FAIL release_rf_wen got=%b exp=0", rf_wen); else passed++;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive(1'b1, 5'd5, 2'b01, 64'h11, 64'h100);
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL b2b_ready0 got=%b exp=1", in_ready); else passed++;
        @(negedge clk);
        drive(1'b1, 5'd6, 2'b01, 64'h22, 64'h104);
        #1;
        total++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 64'h11)
            $display("FAIL b2b_first got=%b/%0d/%h exp=1/5/11", rf_wen, rf_waddr, rf_wdata); else passed++;
        total++; if (retire_valid !== 1'b1 || retire_pc !== 64'h100)
            $display("FAIL b2b_first_retire got=%b/%h exp=1/100", retire_valid, retire_pc); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL b2b_ready1 got=%b exp=1", in_ready); else passed++;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd6 || rf_wdata !== 64'h22)
            $display("FAIL b2b_second got=%b/%0d/%h exp=1/6/22", rf_wen, rf_waddr, rf_wdata); else passed++;
        total++; if (retire_pc !== 64'h104) $display("FAIL b2b_second_pc got=%h exp=104", retire_pc); else passed++;
        exp_instret = exp_instret + 2;
        @(negedge clk); #1;
        total++; if (rf_wen !== 1'b0 || retire_valid !== 1'b0)
            $display("FAIL b2b_idle got=%b/%b exp=0/0", rf_wen, retire_valid); else passed++;
        total++; if (instret !== exp_instret) $display("FAIL b2b_instret got=%0d exp=%0d", instret, exp_instret); else passed++;
    endtask

    task automatic test_load_ext();
        logic [2:0]      lo_t [5]  = '{3'd1, 3'd1, 3'd2, 3'd0, 3'd0};
        logic [1:0]      sz_t [5]  = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b11};
        logic            un_t [5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`ifdef WB_LOAD_EXT_EN
        logic [XLEN-1:0] exp_t [5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_00FF,
                                       64'hFFFF_FFFF_FFFF_8000, 64'hFFFF_FFFF_8000_FF00,
                                       64'h0000_0000_8000_FF00};
`else
        logic [XLEN-1:0] exp_t [5] = '{64'h0000_0000_8000_FF00, 64'h0000_0000_8000_FF00,
                                       64'h0000_0000_8000_FF00, 64'h0000_0000_8000_FF00,
                                       64'h0000_0000_8000_FF00};
`endif
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(1'b1, 5'd8, 2'b10, 64'hDEAD, 64'h300 + 64'(i * 4));
            in_mem_data = 64'h0000_0000_8000_FF00;
            in_addr_lo = lo_t[i]; in_ld_size = sz_t[i]; in_ld_unsigned = un_t[i];
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            total++; if (rf_wen !== 1'b1 || rf_wdata !== exp_t[i])
                $display("FAIL load_ext_%0d got=%b/%h exp=1/%h", i, rf_wen, rf_wdata, exp_t[i]); else passed++;
            exp_instret = exp_instret + 1;
        end
        @(negedge clk); #1;
        total++; if (instret !== exp_instret) $display("FAIL load_instret got=%0d exp=%0d", instret, exp_instret); else passed++;
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        commit_ready = 1'b0;
        drive(1'b1, 5'd9, 2'b11, 64'h0, 64'h200);
        in_csr_data = 64'h99;
        @(negedge clk);
        drive(1'b1, 5'd10, 2'b01, 64'hAB, 64'h204);
        in_csr_data = 64'h0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            total++; if (in_ready !== 1'b0 || rf_wen !== 1'b0 || retire_valid !== 1'b0)
                $display("FAIL bp_stall_%0d got=%b/%b/%b exp=0/0/0", i, in_ready, rf_wen, retire_valid); else passed++;
            total++; if (rf_waddr !== 5'd9 || rf_wdata !== 64'h99 || retire_pc !== 64'h200)
                $display("FAIL bp_hold_%0d got=%0d/%h/%h exp=9/99/200", i, rf_waddr, rf_wdata, retire_pc); else passed++;
        end
        @(negedge clk);
        commit_ready = 1'b1; in_valid = 1'b0;
        #1;
        total++; if (rf_wen !== 1'b1 || retire_valid !== 1'b1 || rf_waddr !== 5'd9)
            $display("FAIL bp_commit got=%b/%b/%0d exp=1/1/9", rf_wen, retire_valid, rf_waddr); else passed++;
        exp_instret = exp_instret + 1;
        @(negedge clk); #1;
        total++; if (retire_valid !== 1'b0) $display("FAIL bp_single got=%b exp=0", retire_valid); else passed++;
        total++; if (instret !== exp_instret) $display("FAIL bp_instret got=%0d exp=%0d", instret, exp_instret); else passed++;
    endtask

    task automatic test_x0_none();
        @(negedge clk);
        drive(1'b1, 5'd0, 2'b01, 64'h55, 64'h400);
        @(negedge clk);
        drive(1'b1, 5'd7, 2'b00, 64'h66, 64'h404);
        #1;
        total++; if (retire_valid !== 1'b1 || rf_wen !== 1'b0 || retire_pc !== 64'h400)
            $display("FAIL x0_write got=%b/%b/%h exp=1/0/400", retire_valid, rf_wen, retire_pc); else passed++;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++; if (retire_valid !== 1'b1 || rf_wen !== 1'b0 || rf_wdata !== '0)
            $display("FAIL sel_none got=%b/%b/%h exp=1/0/0", retire_valid, rf_wen, rf_wdata); else passed++;
        exp_instret = exp_instret + 2;
        @(negedge clk); #1;
        total++; if (instret !== exp_instret) $display("FAIL x0_instret got=%0d exp=%0d", instret, exp_instret); else passed++;
    endtask

    task automatic test_flush();
        @(negedge clk);
        commit_ready = 1'b0;
        drive(1'b1, 5'd11, 2'b01, 64'h77, 64'h500);
        @(negedge clk);
        flush = 1'b1;
        drive(1'b1, 5'd12, 2'b01, 64'h88, 64'h504);
        #1;
        total++; if (retire_valid !== 1'b0 || rf_wen !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL flush_stalled got=%b/%b/%b exp=0/0/0", retire_valid, rf_wen, in_ready); else passed++;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; commit_ready = 1'b1;
        #1;
        total++; if (retire_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL flush_cleared got=%b/%b exp=0/1", retire_valid, in_ready); else passed++;
        // Held entry with commit_ready high: flush blocks the commit and drops the accept.
        drive(1'b1, 5'd13, 2'b01, 64'h99, 64'h508);
        @(negedge clk);
        flush = 1'b1;
        drive(1'b1, 5'd14, 2'b01, 64'hAA, 64'h50C);
        #1;
        total++; if (retire_valid !== 1'b0 || rf_wen !== 1'b0)
            $display("FAIL flush_ready_commit got=%b/%b exp=0/0", retire_valid, rf_wen); else passed++;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        total++; if (retire_valid !== 1'b0 || retire_pc !== 64'h508)
            $display("FAIL flush_discard got=%b/%h exp=0/508", retire_valid, retire_pc); else passed++;
        total++; if (instret !== exp_instret) $display("FAIL flush_instret got=%0d exp=%0d", instret, exp_instret); else passed++;
    endtask

    task automatic test_reset_mid_stall();
        @(negedge clk);
        commit_ready = 1'b0;
        drive(1'b1, 5'd15, 2'b01, 64'hCC, 64'h600);
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1; commit_ready = 1'b1;
        #1;
        total++; if (retire_valid !== 1'b0 || rf_wen !== 1'b0)
            $display("FAIL rst_stall_commit got=%b/%b exp=0/0", retire_valid, rf_wen); else passed++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (retire_valid !== 1'b0 || instret !== '0 || rf_wdata !== '0 || retire_pc !== '0)
            $display("FAIL rst_stall_after got=%b/%0d/%h/%h exp=0/0/0/0", retire_valid, instret, rf_wdata, retire_pc); else passed++;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; commit_ready = 1'b1;
        in_valid = 1'b0; in_pc = '0; in_rd_addr = '0; in_rd_wen = 1'b0; in_sel = 2'b00;
        in_exe_data = '0; in_mem_data = '0; in_csr_data = '0;
        in_ld_size = 2'b00; in_ld_unsigned = 1'b0; in_addr_lo = 3'd0;
        test_reset();
        test_back_to_back();
        test_load_ext();
        test_backpressure();
        test_x0_none();
        test_flush();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
